rr_priority_arbiter: RTL and testbench

Parametrised N-way request arbiter, the successor to the 3-input fixed-priority grant block. It issues a registered one-hot grant under a run-time selectable fixed-priority or round-robin policy. A granted requester keeps ownership until it releases. An optional hold-timeout forces re-arbitration so a greedy requester cannot starve the others. It sits between bus/resource requesters and the shared resource mux, which it drives with `grant_id`.

---
 rtl/arb_pkg.sv | 12 +
 rtl/arb_pick.sv | 50 +++++
 rtl/rr_priority_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_priority_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the N-way request arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam logic ARB_MODE_FIXED = 1'b0;
    localparam logic ARB_MODE_RR    = 1'b1;

endpackage : arb_pkg

// File: rtl/arb_pick.sv
// Combinational rotate-and-priority-encode winner search over a masked
// request vector, starting at start_i and wrapping N_REQ-1 -> 0.
module arb_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         mask_i,
    input  logic [$clog2(N_REQ)-1:0] start_i,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     found_o
);

    localparam int IDW = $clog2(N_REQ);
    localparam int SW  = IDW + 1;

    logic [N_REQ-1:0]   cand_s;
    logic [2*N_REQ-1:0] dbl_s;
    logic [N_REQ-1:0]   rot_s;
    logic [IDW-1:0]     off_s;
    logic [SW-1:0]      sum_s;

    assign cand_s = req_i & ~mask_i;
    assign dbl_s  = {cand_s, cand_s} >> start_i;
    assign rot_s  = dbl_s[N_REQ-1:0];

    // First set bit of the rotated vector is the offset from the start index.
    always_comb begin
        off_s   = '0;
        found_o = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found_o && rot_s[k]) begin
                found_o = 1'b1;
                off_s   = IDW'(k);
            end else begin
                found_o = found_o;
            end
        end
    end

    // Map the rotated offset back to an absolute requester index.
    always_comb begin
        sum_s = {1'b0, start_i} + {1'b0, off_s};
        if (sum_s >= SW'(N_REQ)) begin
            idx_o = IDW'(sum_s - SW'(N_REQ));
        end else begin
            idx_o = IDW'(sum_s);
        end
    end

endmodule : arb_pick

// File: rtl/rr_priority_arbiter.sv
// N-way arbiter with registered one-hot grant, fixed or round-robin policy.
// Define RR_PRIORITY_ARB_HOLD_TIMEOUT_EN to bound ownership to MAX_HOLD cycles.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [N_REQ-1:0]         req,
    input  logic                     done,
    output logic [N_REQ-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int IDW = $clog2(N_REQ);

    if (N_REQ < 2 || MAX_HOLD < 1) begin : g_bad_cfg
        $error("rr_priority_arbiter: N_REQ must be >= 2 and MAX_HOLD >= 1");
    end

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic             timeout_s;
    logic             release_s;
    logic             arb_s;
    logic [N_REQ-1:0] mask_s;
    logic [IDW-1:0]   start_s;
    logic [IDW-1:0]   win_s;
    logic             found_s;

`ifdef RR_PRIORITY_ARB_HOLD_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_q, hold_d;

    assign timeout_s = (state_q == OWNED) && (hold_q == HW'(MAX_HOLD - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Any combination of release causes collapses into a single re-arbitration.
    assign release_s = (state_q == OWNED) && (!req[id_q] || done || timeout_s);
    assign arb_s     = (state_q == IDLE) || release_s;
    assign mask_s    = timeout_s ? grant_q : '0;
    assign start_s   = (mode == ARB_MODE_RR) ? ptr_q : '0;

    arb_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i   (req),
        .mask_i  (mask_s),
        .start_i (start_s),
        .idx_o   (win_s),
        .found_o (found_s)
    );

    // Next-state: load a winner directly on arbitration, otherwise hold.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
`ifdef RR_PRIORITY_ARB_HOLD_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        if (arb_s) begin
            if (found_s) begin
                state_d        = OWNED;
                grant_d        = '0;
                grant_d[win_s] = 1'b1;
                valid_d        = 1'b1;
                id_d           = win_s;
                ptr_d          = (win_s == IDW'(N_REQ - 1)) ? '0 : win_s + IDW'(1);
`ifdef RR_PRIORITY_ARB_HOLD_TIMEOUT_EN
                hold_d         = '0;
`endif
            end else begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        end else begin
`ifdef RR_PRIORITY_ARB_HOLD_TIMEOUT_EN
            hold_d  = hold_q + HW'(1);
`else
            state_d = state_q;
`endif
        end
    end

    // Grant, owner index and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef RR_PRIORITY_ARB_HOLD_TIMEOUT_EN
    // Ownership-length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;

endmodule : rr_priority_arbiter

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench for rr_priority_arbiter (N_REQ=4, MAX_HOLD=4), using an
// integer-level reference model; follows RR_PRIORITY_ARB_HOLD_TIMEOUT_EN.
module tb_rr_priority_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;
`ifdef RR_PRIORITY_ARB_HOLD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;

    typedef struct packed {
        logic [N-1:0] g;
        logic         v;
        logic [1:0]   id;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    int m_owner;
    int m_ptr;
    int m_hold;
    int m_id;

    rr_priority_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_id    = 0;
    endfunction

    // One clock edge of the arbiter, expressed as spec rules over integers.
    function automatic void model_step(input logic [N-1:0] r, input logic d, input logic md);
        int  start;
        int  mask;
        int  win;
        int  idx;
        bit  tmo;
        bit  rel;
        tmo  = 1'b0;
        rel  = 1'b0;
        mask = -1;
        win  = -1;
        if (m_owner >= 0) begin
            tmo = TMO_EN && (m_hold == MH - 1);
            rel = (r[m_owner[1:0]] == 1'b0) || d || tmo;
            if (tmo) mask = m_owner;
        end
        if (m_owner < 0 || rel) begin
            start = md ? m_ptr : 0;
            for (int k = 0; k < N; k++) begin
                idx = (start + k) % N;
                if (win < 0 && r[idx[1:0]] && idx != mask) win = idx;
            end
            if (win >= 0) begin
                m_owner = win;
                m_id    = win;
                m_ptr   = (win + 1) % N;
                m_hold  = 0;
            end else begin
                m_owner = -1;
            end
        end else begin
            m_hold++;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.v  = (m_owner >= 0);
        e.id = m_id[1:0];
        return e;
    endfunction

    task automatic drive(input logic [N-1:0] r, input logic d, input logic md);
        @(negedge clk);
        req  = r;
        done = d;
        mode = md;
        model_step(r, d, md);
        exp_q.push_back(model_out());
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL %s: got grant=%b valid=%b id=%0d, expected grant=0000 valid=0 id=0",
                     tag, grant, grant_valid, grant_id);
        end
    endtask

    // Monitor: one expected response per clock edge after stimulus.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({grant, grant_valid, grant_id} !== e) begin
                    n_fail++;
                    $display("FAIL grant_check t=%0t: got grant=%b valid=%b id=%0d, expected grant=%b valid=%b id=%0d",
                             $time, grant, grant_valid, grant_id, e.g, e.v, e.id);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [N-1:0] r;
        logic         d;
        logic         md;
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        mode  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        #1;
        rst_n = 1'b1;

        // Fixed priority: 1010 -> owner 1, drop req[1] -> owner 3 without a bubble.
        drive(4'b0000, 1'b0, 1'b0);
        repeat (3) drive(4'b1010, 1'b0, 1'b0);
        repeat (3) drive(4'b1000, 1'b0, 1'b0);
        repeat (2) drive(4'b0000, 1'b0, 1'b0);

        // Round-robin, all requesting; then a done pulse hands over.
        repeat (22) drive(4'b1111, 1'b0, 1'b1);
        drive(4'b1111, 1'b1, 1'b1);
        repeat (4) drive(4'b1111, 1'b0, 1'b1);
        repeat (2) drive(4'b0000, 1'b0, 1'b1);

        // Sole requester: timeout leaves a one-cycle gap before re-grant.
        repeat (12) drive(4'b1000, 1'b0, 1'b1);
        repeat (2) drive(4'b0000, 1'b0, 1'b0);

        // Owner 0 drops, pulses done and (with timeout) times out together.
        repeat (4) drive(4'b0101, 1'b0, 1'b0);
        drive(4'b0100, 1'b1, 1'b0);
        drive(4'b1111, 1'b1, 1'b1);
        drive(4'b1011, 1'b1, 1'b1);
        repeat (2) drive(4'b0000, 1'b0, 1'b0);

        // Random traffic with sticky requests, occasional done and mode flips.
        r  = 4'b0000;
        md = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            d = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) md = ~md;
            drive(r, d, md);
        end

        // Asynchronous reset in the middle of an ownership.
        repeat (3) drive(4'b1100, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (3) drive(4'b0110, 1'b0, 1'b1);
        repeat (3) drive(4'b0000, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_rr_priority_arbiter
